basket_controller: RTL and testbench
====================================

BASKET_CONTROLLER -- requirements
Module: basket_controller

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: CLOCK_50 and RESET_N.
REQ-002 CLOCK_50  in  1  system clock; all state changes on the rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 ENABLE  in  1  one-cycle request pulse from the terminal state machine.
REQ-005 ProductID  in  4  product to add, update or remove; valid IDs are 0-11.
REQ-006 ProductQuantity  in  4  quantity to add (1-15); 0 means remove the item.
REQ-007 CLEAR  in  1  one-cycle checkout/cancel pulse that empties the basket.
REQ-008 RD_IDX  in  3  slot index for readout.
REQ-009 RD_ID, RD_QTY  out  4 each  registered content of slot RD_IDX.
REQ-010 ItemCount  out  4  number of occupied slots (0-8).
REQ-011 TotalPrice  out  12  sum of price(ID) x qty over all slots.
REQ-012 BUSY  out  1  high whenever the state is not IDLE.
REQ-013 DONE  out  1  one-cycle success pulse.
REQ-014 ERR  out  1  one-cycle failure pulse.
REQ-015 ERR_CODE  out  2  01 = invalid ID, 10 = basket full, 11 = ID not found; held until the next request.

Function
REQ-016 The price ROM SHALL map IDs 0-11 to 3, 5, 7, 10, 12, 15, 2, 4, 6, 8, 20, 25.
REQ-017 The basket SHALL hold 8 slots of {ID, qty}, with occupied slots packed in indices 0..ItemCount-1.
REQ-018 The FSM SHALL have states IDLE, SCAN, UPDATE and RESP.
REQ-019 In IDLE, an ENABLE with a valid ID SHALL latch ProductID and ProductQuantity and enter SCAN.
REQ-020 In IDLE, an ENABLE with ID > 11 SHALL go directly to RESP with ERR=1 and ERR_CODE=01, leaving the basket unchanged.
REQ-021 SCAN SHALL compare one slot per cycle, starting at slot 0, for max(ItemCount,1) cycles, recording the first matching index, then enter UPDATE.
REQ-022 On a match with qty>0, UPDATE SHALL set slot qty = min(old+qty, 15) and adjust TotalPrice by price x (new-old).
REQ-023 On a match with qty=0, UPDATE SHALL:
- copy slot[ItemCount-1] into the matched slot;
- decrement ItemCount;
- subtract price x old from TotalPrice.
REQ-024 With no match, qty>0 and ItemCount<8, UPDATE SHALL append the item at slot ItemCount, increment ItemCount and add price x qty to TotalPrice.
REQ-025 With no match, qty>0 and ItemCount=8, the outcome SHALL be ERR_CODE=10 with the basket unchanged.
REQ-026 With no match and qty=0, the outcome SHALL be ERR_CODE=11 with the basket unchanged.
REQ-027 RESP SHALL last exactly one cycle, pulse DONE or ERR (never both), and return to IDLE.
REQ-028 Latency: with k = max(ItemCount,1), DONE/ERR SHALL be high in cycle k+2 after the ENABLE-sampling edge; ItemCount and TotalPrice SHALL already be updated in that cycle.
REQ-029 ENABLE while BUSY SHALL be ignored; it is neither queued nor reported.
REQ-030 CLEAR in any state SHALL, on the next edge, zero all slots, ItemCount and TotalPrice, abort any operation, return to IDLE and emit no DONE/ERR.
REQ-031 CLEAR and ENABLE in the same cycle: CLEAR SHALL win and ENABLE SHALL be dropped.
REQ-032 TotalPrice arithmetic SHALL be 12-bit unsigned; the maximum 8x15x25=3000 never overflows.
REQ-033 RD_ID/RD_QTY SHALL reflect slot RD_IDX one cycle after RD_IDX changes; unoccupied slots SHALL read 0.

Reset
REQ-034 On RESET_N low, asynchronously: state=IDLE; all slots, ItemCount, TotalPrice, RD_ID, RD_QTY = 0; BUSY, DONE, ERR = 0; ERR_CODE=00.
REQ-035 Reset asserted mid-operation SHALL abandon the operation with no DONE/ERR pulse.

Verification
REQ-036 Empty basket, ENABLE ID=3 qty=2 -> DONE in cycle 3, ItemCount=1, TotalPrice=20, RD_IDX=0 gives RD_ID=3, RD_QTY=2.
REQ-037 Then ENABLE ID=3 qty=15 -> qty saturates to 15, TotalPrice=150, ItemCount=1.
REQ-038 Fill IDs 0-7 with qty 1 (total 58), then ENABLE ID=10 qty=1 -> ERR, ERR_CODE=10, totals unchanged; then ENABLE ID=2 qty=0 -> DONE, ItemCount=7, TotalPrice=51, slot 2 now holds ID 7.
REQ-039 ENABLE ID=13 -> ERR with ERR_CODE=01 one cycle later; ENABLE ID=5 qty=0 on an empty basket -> ERR_CODE=11.
REQ-040 Assert CLEAR during SCAN, with ENABLE in the same cycle -> no DONE/ERR, ItemCount=0, TotalPrice=0, BUSY=0.
REQ-041 Assert RESET_N low mid-UPDATE -> all outputs 0 immediately; a subsequent ENABLE ID=11 qty=4 -> TotalPrice=100.

Source files
------------

// File: rtl/basket_controller.sv
// rtl/basket_controller.sv - shopping basket of 8 {ID, qty} slots with running total price
// Linear-scan FSM: IDLE -> SCAN (one slot per cycle) -> UPDATE -> RESP.
module basket_controller (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic        ENABLE,
    input  logic [3:0]  ProductID,
    input  logic [3:0]  ProductQuantity,
    input  logic        CLEAR,
    input  logic [2:0]  RD_IDX,
    output logic [3:0]  RD_ID,
    output logic [3:0]  RD_QTY,
    output logic [3:0]  ItemCount,
    output logic [11:0] TotalPrice,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [1:0]  ERR_CODE
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_UPDATE, S_RESP} state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_slot_id  [8];
    logic [3:0]  r_slot_qty [8];
    logic [3:0]  r_count;
    logic [11:0] r_total;
    logic [3:0]  r_id, r_qty;
    logic [2:0]  r_scan_idx, r_match_idx;
    logic        r_found, r_done, r_err;
    logic [1:0]  r_err_code;
    logic [3:0]  r_rd_id, r_rd_qty;

    logic        w_id_valid, w_scan_last, w_hit;
    logic [11:0] w_price;
    logic [3:0]  w_old_qty, w_new_qty, w_last;
    logic [4:0]  w_sum;

    function automatic logic [4:0] price(input logic [3:0] id);
        case (id)
            4'd0:    price = 5'd3;
            4'd1:    price = 5'd5;
            4'd2:    price = 5'd7;
            4'd3:    price = 5'd10;
            4'd4:    price = 5'd12;
            4'd5:    price = 5'd15;
            4'd6:    price = 5'd2;
            4'd7:    price = 5'd4;
            4'd8:    price = 5'd6;
            4'd9:    price = 5'd8;
            4'd10:   price = 5'd20;
            4'd11:   price = 5'd25;
            default: price = 5'd0;
        endcase
    endfunction

    assign w_id_valid  = (ProductID <= 4'd11);
    // k = max(ItemCount,1) scan cycles: the last one is when idx+1 reaches the count
    assign w_scan_last = (({1'b0, r_scan_idx} + 4'd1) >= r_count);
    assign w_hit       = ({1'b0, r_scan_idx} < r_count) && (r_slot_id[r_scan_idx] == r_id);
    assign w_price     = 12'(price(r_id));
    assign w_old_qty   = r_slot_qty[r_match_idx];
    assign w_sum       = {1'b0, w_old_qty} + {1'b0, r_qty};
    assign w_new_qty   = (w_sum > 5'd15) ? 4'd15 : w_sum[3:0];
    assign w_last      = r_count - 4'd1;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (ENABLE) w_next = w_id_valid ? S_SCAN : S_RESP;
            S_SCAN:   if (w_scan_last) w_next = S_UPDATE;
            S_UPDATE: w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
        if (CLEAR) w_next = S_IDLE;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 8; i++) begin
                r_slot_id[i]  <= 4'd0;
                r_slot_qty[i] <= 4'd0;
            end
            r_count     <= 4'd0;
            r_total     <= 12'd0;
            r_id        <= 4'd0;
            r_qty       <= 4'd0;
            r_scan_idx  <= 3'd0;
            r_match_idx <= 3'd0;
            r_found     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 2'b00;
            r_rd_id     <= 4'd0;
            r_rd_qty    <= 4'd0;
        end else begin
            r_rd_id  <= r_slot_id[RD_IDX];
            r_rd_qty <= r_slot_qty[RD_IDX];
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            if (CLEAR) begin
                for (int i = 0; i < 8; i++) begin
                    r_slot_id[i]  <= 4'd0;
                    r_slot_qty[i] <= 4'd0;
                end
                r_count <= 4'd0;
                r_total <= 12'd0;
            end else begin
                case (r_state)
                    S_IDLE: if (ENABLE) begin
                        if (w_id_valid) begin
                            r_id       <= ProductID;
                            r_qty      <= ProductQuantity;
                            r_scan_idx <= 3'd0;
                            r_found    <= 1'b0;
                            r_err_code <= 2'b00;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= 2'b01;
                        end
                    end
                    S_SCAN: begin
                        if (w_hit && !r_found) begin
                            r_found     <= 1'b1;
                            r_match_idx <= r_scan_idx;
                        end
                        r_scan_idx <= r_scan_idx + 3'd1;
                    end
                    S_UPDATE: begin
                        if (r_found && r_qty != 4'd0) begin
                            r_slot_qty[r_match_idx] <= w_new_qty;
                            r_total <= r_total - w_price * 12'(w_old_qty) + w_price * 12'(w_new_qty);
                            r_done  <= 1'b1;
                        end else if (r_found) begin
                            // move the last slot into the hole; zeroing last wins when they coincide
                            r_slot_id[r_match_idx]  <= r_slot_id[w_last[2:0]];
                            r_slot_qty[r_match_idx] <= r_slot_qty[w_last[2:0]];
                            r_slot_id[w_last[2:0]]  <= 4'd0;
                            r_slot_qty[w_last[2:0]] <= 4'd0;
                            r_count <= w_last;
                            r_total <= r_total - w_price * 12'(w_old_qty);
                            r_done  <= 1'b1;
                        end else if (r_qty != 4'd0 && !r_count[3]) begin
                            r_slot_id[r_count[2:0]]  <= r_id;
                            r_slot_qty[r_count[2:0]] <= r_qty;
                            r_count <= r_count + 4'd1;
                            r_total <= r_total + w_price * 12'(r_qty);
                            r_done  <= 1'b1;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= (r_qty != 4'd0) ? 2'b10 : 2'b11;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign RD_ID      = r_rd_id;
    assign RD_QTY     = r_rd_qty;
    assign ItemCount  = r_count;
    assign TotalPrice = r_total;
    assign BUSY       = (r_state != S_IDLE);
    assign DONE       = r_done;
    assign ERR        = r_err;
    assign ERR_CODE   = r_err_code;

endmodule

// File: tb/tb_basket_controller.sv
// tb/tb_basket_controller.sv - directed table-driven bench for basket_controller
module tb_basket_controller;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ENABLE = 1'b0;
    logic [3:0]  ProductID = 4'd0;
    logic [3:0]  ProductQuantity = 4'd0;
    logic        CLEAR = 1'b0;
    logic [2:0]  RD_IDX = 3'd0;
    logic [3:0]  RD_ID, RD_QTY, ItemCount;
    logic [11:0] TotalPrice;
    logic        BUSY, DONE, ERR;
    logic [1:0]  ERR_CODE;

    int n_pass = 0;
    int n_total = 0;

    basket_controller dut (
        .CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .ENABLE(ENABLE),
        .ProductID(ProductID), .ProductQuantity(ProductQuantity),
        .CLEAR(CLEAR), .RD_IDX(RD_IDX), .RD_ID(RD_ID), .RD_QTY(RD_QTY),
        .ItemCount(ItemCount), .TotalPrice(TotalPrice), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit         clr;
        logic [3:0] id;
        logic [3:0] qty;
        bit         err;
        logic [1:0] code;
        int         cnt;
        int         tot;
        int         lat;
        logic [2:0] rd;
        int         rid;
        int         rqty;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_clear();
        @(negedge CLOCK_50);
        CLEAR = 1'b1;
        @(posedge CLOCK_50);
        #1 CLEAR = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [3:0] id, input logic [3:0] qty,
                         input bit err, input logic [1:0] code, input int cnt, input int tot,
                         input int lat, input logic [2:0] rd, input int rid, input int rqty);
        int cyc;
        @(negedge CLOCK_50);
        ENABLE = 1'b1;
        ProductID = id;
        ProductQuantity = qty;
        RD_IDX = rd;
        @(posedge CLOCK_50);
        #1 ENABLE = 1'b0;
        cyc = 1;
        while (!(DONE || ERR) && cyc < 40) begin
            @(posedge CLOCK_50);
            #1 cyc++;
        end
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " done"}, int'(DONE), int'(!err));
        chk({tag, " err"}, int'(ERR), int'(err));
        chk({tag, " err_code"}, int'(ERR_CODE), int'(code));
        chk({tag, " count"}, int'(ItemCount), cnt);
        chk({tag, " total"}, int'(TotalPrice), tot);
        @(posedge CLOCK_50);
        #1;
        chk({tag, " pulse_end"}, int'(DONE | ERR), 0);
        chk({tag, " rd_id"}, int'(RD_ID), rid);
        chk({tag, " rd_qty"}, int'(RD_QTY), rqty);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " count"}, int'(ItemCount), 0);
        chk({tag, " total"}, int'(TotalPrice), 0);
        chk({tag, " busy"}, int'(BUSY), 0);
        chk({tag, " done"}, int'(DONE), 0);
        chk({tag, " err"}, int'(ERR), 0);
        chk({tag, " err_code"}, int'(ERR_CODE), 0);
        chk({tag, " rd_id"}, int'(RD_ID), 0);
        chk({tag, " rd_qty"}, int'(RD_QTY), 0);
    endtask

    initial begin
        int seen;
        //          clr id     qty    err code   cnt tot  lat rd    rid rqty
        tbl[0]  = '{1'b0, 4'd3,  4'd2,  1'b0, 2'b00, 1, 20,  3,  3'd0, 3, 2};
        tbl[1]  = '{1'b0, 4'd3,  4'd15, 1'b0, 2'b00, 1, 150, 3,  3'd0, 3, 15};
        tbl[2]  = '{1'b1, 4'd0,  4'd1,  1'b0, 2'b00, 1, 3,   3,  3'd0, 0, 1};
        tbl[3]  = '{1'b0, 4'd1,  4'd1,  1'b0, 2'b00, 2, 8,   3,  3'd1, 1, 1};
        tbl[4]  = '{1'b0, 4'd2,  4'd1,  1'b0, 2'b00, 3, 15,  4,  3'd2, 2, 1};
        tbl[5]  = '{1'b0, 4'd3,  4'd1,  1'b0, 2'b00, 4, 25,  5,  3'd3, 3, 1};
        tbl[6]  = '{1'b0, 4'd4,  4'd1,  1'b0, 2'b00, 5, 37,  6,  3'd4, 4, 1};
        tbl[7]  = '{1'b0, 4'd5,  4'd1,  1'b0, 2'b00, 6, 52,  7,  3'd5, 5, 1};
        tbl[8]  = '{1'b0, 4'd6,  4'd1,  1'b0, 2'b00, 7, 54,  8,  3'd6, 6, 1};
        tbl[9]  = '{1'b0, 4'd7,  4'd1,  1'b0, 2'b00, 8, 58,  9,  3'd7, 7, 1};
        tbl[10] = '{1'b0, 4'd10, 4'd1,  1'b1, 2'b10, 8, 58,  10, 3'd7, 7, 1};
        tbl[11] = '{1'b0, 4'd2,  4'd0,  1'b0, 2'b00, 7, 51,  10, 3'd2, 7, 1};
        tbl[12] = '{1'b0, 4'd13, 4'd0,  1'b1, 2'b01, 7, 51,  1,  3'd6, 6, 1};
        tbl[13] = '{1'b0, 4'd4,  4'd3,  1'b0, 2'b00, 7, 87,  9,  3'd4, 4, 4};
        tbl[14] = '{1'b0, 4'd9,  4'd5,  1'b0, 2'b00, 8, 127, 9,  3'd7, 9, 5};
        tbl[15] = '{1'b1, 4'd5,  4'd0,  1'b1, 2'b11, 0, 0,   3,  3'd7, 0, 0};

        repeat (3) @(posedge CLOCK_50);
        #1 chk_all_zero("reset");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].clr) do_clear();
            do_op($sformatf("vec%0d", i), tbl[i].id, tbl[i].qty, tbl[i].err, tbl[i].code,
                  tbl[i].cnt, tbl[i].tot, tbl[i].lat, tbl[i].rd, tbl[i].rid, tbl[i].rqty);
        end

        // ENABLE during SCAN is dropped: only the first request lands
        @(negedge CLOCK_50);
        ENABLE = 1'b1; ProductID = 4'd8; ProductQuantity = 4'd2; RD_IDX = 3'd0;
        @(negedge CLOCK_50);
        ProductID = 4'd9; ProductQuantity = 4'd3;
        @(negedge CLOCK_50);
        ENABLE = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge CLOCK_50);
            #1 seen += int'(DONE);
        end
        chk("busy_enable dones", seen, 1);
        chk("busy_enable count", int'(ItemCount), 1);
        chk("busy_enable total", int'(TotalPrice), 12);
        chk("busy_enable rd_id", int'(RD_ID), 8);

        // CLEAR together with ENABLE while scanning
        @(negedge CLOCK_50);
        ENABLE = 1'b1; ProductID = 4'd5; ProductQuantity = 4'd1;
        @(posedge CLOCK_50);
        #1 chk("clear_scan busy", int'(BUSY), 1);
        @(negedge CLOCK_50);
        CLEAR = 1'b1;
        @(posedge CLOCK_50);
        #1 CLEAR = 1'b0; ENABLE = 1'b0;
        seen = 0;
        repeat (6) begin
            chk("clear_scan busy_low", int'(BUSY), 0);
            seen += int'(DONE | ERR);
            @(posedge CLOCK_50);
            #1;
        end
        chk("clear_scan pulses", seen, 0);
        chk("clear_scan count", int'(ItemCount), 0);
        chk("clear_scan total", int'(TotalPrice), 0);

        // reset during UPDATE
        do_op("pre_rst", 4'd3, 4'd2, 1'b0, 2'b00, 1, 20, 3, 3'd0, 3, 2);
        @(negedge CLOCK_50);
        ENABLE = 1'b1; ProductID = 4'd6; ProductQuantity = 4'd1;
        @(posedge CLOCK_50);
        #1 ENABLE = 1'b0;
        @(posedge CLOCK_50);
        #1 chk("mid_update busy", int'(BUSY), 1);
        RESET_N = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge CLOCK_50);
            #1 seen += int'(DONE | ERR);
        end
        chk("post_reset pulses", seen, 0);
        do_op("post_reset", 4'd11, 4'd4, 1'b0, 2'b00, 1, 100, 3, 3'd0, 11, 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
